// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC and runs a single-outstanding request/response
// exchange with instruction memory, presenting instr / PC+4 / valid to IF/ID.
module if_fetch_unit #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] redirect_pc_i,
  output logic             imem_req_o,
  output logic [WIDTH-1:0] imem_addr_o,
  input  logic             imem_ready_i,
  input  logic             imem_rvalid_i,
  input  logic [WIDTH-1:0] imem_rdata_i,
  output logic [WIDTH-1:0] instr_if32,
  output logic [WIDTH-1:0] pc_plus4_if32,
  output logic             valid_if_o,
  output logic [1:0]       state_dbg_o
);

  // Handshake: a request is taken when imem_req_o && imem_ready_i at a rising edge;
  // exactly one imem_rvalid_i pulse answers it, and only a WAIT-state pulse is observed.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_hold;
  logic             r_discard;

  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_pc_plus4;

  assign w_target   = redirect_pc_i & ~(WIDTH'(3));
  assign w_pc_plus4 = r_pc + WIDTH'(4);

  assign imem_req_o    = (r_state == S_REQ);
  assign imem_addr_o   = r_pc;
  assign valid_if_o    = (r_state == S_DONE);
  assign instr_if32    = valid_if_o ? r_hold : '0;
  assign pc_plus4_if32 = w_pc_plus4;
  assign state_dbg_o   = r_state;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= S_REQ;
      r_pc      <= RESET_PC;
      r_hold    <= '0;
      r_discard <= 1'b0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (redirect_i)        r_pc    <= w_target;
          else if (imem_ready_i) r_state <= S_WAIT;
        end
        S_WAIT: begin
          // The in-flight response belongs to the old PC: drop it when it lands.
          if (redirect_i) begin
            r_pc <= w_target;
            if (imem_rvalid_i) begin
              r_discard <= 1'b0;
              r_state   <= S_REQ;
            end else begin
              r_discard <= 1'b1;
            end
          end else if (imem_rvalid_i) begin
            if (r_discard) begin
              r_discard <= 1'b0;
              r_state   <= S_REQ;
            end else begin
              r_hold  <= imem_rdata_i;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (redirect_i) begin
            r_pc    <= w_target;
            r_state <= S_REQ;
          end else if (!stall_i) begin
            r_pc    <= w_pc_plus4;
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: behavioural instruction memory, expected-instruction queue,
// a vector table for fetch latency, and hand-built redirect / stall / reset sequences.
module tb_if_fetch_unit;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] target;
    int           ready_delay;
    int           mem_lat;
    logic [W-1:0] exp_addr;
    logic [W-1:0] exp_instr;
    logic [W-1:0] exp_pc4;
    int           exp_lat;
  } vec_t;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         stall_i;
  logic         redirect_i;
  logic [W-1:0] redirect_pc_i;
  logic         imem_req_o;
  logic [W-1:0] imem_addr_o;
  logic         imem_ready_i;
  logic         imem_rvalid_i;
  logic [W-1:0] imem_rdata_i;
  logic [W-1:0] instr_if32;
  logic [W-1:0] pc_plus4_if32;
  logic         valid_if_o;
  logic [1:0]   state_dbg_o;

  logic         w_req;
  logic [W-1:0] w_addr;
  logic         w_rvalid;
  logic [W-1:0] w_instr;
  logic [W-1:0] w_pc4;
  logic         w_valid;
  logic [1:0]   w_state;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           mem_cnt  = 0;
  int           mem_lat  = 1;
  logic [W-1:0] mem_addr;
  logic         w_pend;
  logic         prev_valid;
  logic [2*W-1:0] exp_q[$];
  vec_t         vecs[4];

  always #5 clk_i = ~clk_i;

  if_fetch_unit #(.WIDTH(W), .RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ready_i(imem_ready_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_if32(instr_if32), .pc_plus4_if32(pc_plus4_if32), .valid_if_o(valid_if_o),
    .state_dbg_o(state_dbg_o)
  );

  if_fetch_unit #(.WIDTH(W), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk_i(clk_i), .reset_i(reset_i), .stall_i(1'b0), .redirect_i(1'b0),
    .redirect_pc_i(32'h0), .imem_req_o(w_req), .imem_addr_o(w_addr),
    .imem_ready_i(1'b1), .imem_rvalid_i(w_rvalid), .imem_rdata_i(32'h1111_2222),
    .instr_if32(w_instr), .pc_plus4_if32(w_pc4), .valid_if_o(w_valid),
    .state_dbg_o(w_state)
  );

  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return (a == 32'h0) ? 32'h2002_0005 : {8'hAC, a[23:0]};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock cycle; called at a negedge with this cycle's controls already set.
  task automatic cyc();
    logic         acc;
    logic         w_acc;
    logic [W-1:0] acc_addr;
    logic [2*W-1:0] e;
    imem_rvalid_i = (mem_cnt == 1);
    imem_rdata_i  = (mem_cnt == 1) ? mem_word(mem_addr) : 32'hDEAD_BEEF;
    w_rvalid      = w_pend;
    #1;
    acc      = imem_req_o && imem_ready_i && !reset_i;
    acc_addr = imem_addr_o;
    w_acc    = w_req && !reset_i;
    @(posedge clk_i);
    if (mem_cnt > 0) mem_cnt--;
    if (acc) begin
      mem_cnt  = mem_lat;
      mem_addr = acc_addr;
    end
    w_pend = w_acc;
    @(negedge clk_i);
    if (valid_if_o && !prev_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got instr %h pc4 %h, expected no instruction", instr_if32, pc_plus4_if32);
      end else begin
        e = exp_q.pop_front();
        chk("sb_instr", instr_if32, e[2*W-1:W]);
        chk("sb_pc4", pc_plus4_if32, e[W-1:0]);
      end
    end
    prev_valid = valid_if_o;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    vecs[0] = '{32'h0000_0043, 0, 1, 32'h0000_0040, 32'hAC00_0040, 32'h0000_0044, 2};
    vecs[1] = '{32'h0000_1002, 2, 1, 32'h0000_1000, 32'hAC00_1000, 32'h0000_1004, 4};
    vecs[2] = '{32'h00AB_CDEF, 1, 3, 32'h00AB_CDEC, 32'hACAB_CDEC, 32'h00AB_CDF0, 5};
    vecs[3] = '{32'hFFFF_FFFF, 0, 2, 32'hFFFF_FFFC, 32'hACFF_FFFC, 32'h0000_0000, 3};

    reset_i = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_ready_i = 1'b1; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    w_rvalid = 1'b0; w_pend = 1'b0; prev_valid = 1'b0; mem_addr = '0;
    repeat (2) @(negedge clk_i);

    chk("rst_valid", valid_if_o, 0);
    chk("rst_instr", instr_if32, 0);
    chk("rst_pc4", pc_plus4_if32, 32'h4);
    chk("rst_req", imem_req_o, 1);
    chk("rst_state", state_dbg_o, 0);
    chk("rst_wrap_pc4", w_pc4, 32'h0);
    reset_i = 1'b0;

    // Zero-wait fetch from reset.
    chk("t1_req0", imem_req_o, 1);
    chk("t1_addr0", imem_addr_o, 32'h0);
    exp_q.push_back({32'h2002_0005, 32'h4});
    cyc();
    chk("t1_c1_valid", valid_if_o, 0);
    chk("t1_c1_state", state_dbg_o, 1);
    cyc();
    chk("t1_c2_valid", valid_if_o, 1);
    chk("t1_c2_instr", instr_if32, 32'h2002_0005);
    chk("t1_c2_pc4", pc_plus4_if32, 32'h4);
    cyc();
    chk("t1_c3_req", imem_req_o, 1);
    chk("t1_c3_addr", imem_addr_o, 32'h4);

    // Stall held in DONE for three cycles.
    exp_q.push_back({32'hAC00_0004, 32'h8});
    cyc(); cyc();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t2_hold_valid", valid_if_o, 1);
      chk("t2_hold_instr", instr_if32, 32'hAC00_0004);
      chk("t2_hold_pc4", pc_plus4_if32, 32'h8);
      chk("t2_hold_req", imem_req_o, 0);
    end
    stall_i = 1'b0;
    cyc();
    chk("t2_after_addr", imem_addr_o, 32'h8);
    exp_q.push_back({32'hAC00_0008, 32'hC});
    cyc(); cyc();
    chk("t2_next_valid", valid_if_o, 1);
    cyc();
    chk("t2_next_addr", imem_addr_o, 32'hC);

    // Redirect while waiting; response arrives a cycle later and must be dropped.
    mem_lat = 2;
    cyc();
    chk("t3_wait", state_dbg_o, 1);
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0043;
    cyc();
    redirect_i = 1'b0;
    chk("t3_still_wait", state_dbg_o, 1);
    chk("t3_valid0", valid_if_o, 0);
    cyc();
    chk("t3_drop_valid", valid_if_o, 0);
    chk("t3_req", imem_req_o, 1);
    chk("t3_addr", imem_addr_o, 32'h40);
    mem_lat = 1;
    exp_q.push_back({32'hAC00_0040, 32'h44});
    cyc(); cyc();
    chk("t3_fetch_valid", valid_if_o, 1);
    cyc();
    chk("t3_next_addr", imem_addr_o, 32'h44);

    // Redirect coinciding with the response.
    cyc();
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0100;
    cyc();
    redirect_i = 1'b0;
    chk("t4_state", state_dbg_o, 0);
    chk("t4_req", imem_req_o, 1);
    chk("t4_addr", imem_addr_o, 32'h100);
    chk("t4_valid", valid_if_o, 0);

    // Memory not ready for four cycles, redirect in the second.
    imem_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t5_req", imem_req_o, 1);
      chk("t5_addr", imem_addr_o, (i < 2) ? 32'h100 : 32'h200);
      redirect_i = (i == 1);
      redirect_pc_i = 32'h0000_0200;
      cyc();
    end
    redirect_i = 1'b0;
    imem_ready_i = 1'b1;
    exp_q.push_back({32'hAC00_0200, 32'h204});
    cyc(); cyc();
    chk("t5_valid", valid_if_o, 1);
    cyc();
    chk("t5_next_addr", imem_addr_o, 32'h204);

    // Vector table: redirect target, ready delay, memory latency.
    foreach (vecs[v]) begin
      imem_ready_i = 1'b0;
      redirect_i = 1'b1; redirect_pc_i = vecs[v].target;
      cyc();
      redirect_i = 1'b0;
      chk("vec_addr", imem_addr_o, vecs[v].exp_addr);
      mem_lat = vecs[v].mem_lat;
      exp_q.push_back({vecs[v].exp_instr, vecs[v].exp_pc4});
      k = 0;
      imem_ready_i = (k >= vecs[v].ready_delay);
      while (!valid_if_o && k < 20) begin
        cyc();
        k++;
        imem_ready_i = (k >= vecs[v].ready_delay);
      end
      chk("vec_latency", k, vecs[v].exp_lat);
      cyc();
      chk("vec_next_addr", imem_addr_o, vecs[v].exp_pc4);
    end
    imem_ready_i = 1'b1;
    mem_lat = 1;

    // Asynchronous reset mid-WAIT.
    imem_ready_i = 1'b0;
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0080;
    cyc();
    redirect_i = 1'b0;
    imem_ready_i = 1'b1;
    cyc();
    chk("t6_pre_state", state_dbg_o, 1);
    chk("t6_pre_pc4", pc_plus4_if32, 32'h84);
    imem_rvalid_i = 1'b0;
    w_rvalid = 1'b0;
    #2;
    reset_i = 1'b1;
    #1;
    chk("t6_rst_valid", valid_if_o, 0);
    chk("t6_rst_instr", instr_if32, 0);
    chk("t6_rst_pc4", pc_plus4_if32, 32'h4);
    chk("t6_rst_req", imem_req_o, 1);
    chk("t6_wrap_pc4", w_pc4, 32'h0);
    @(posedge clk_i);
    mem_cnt = 0; w_pend = 1'b0; prev_valid = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b0;
    chk("t6_addr0", imem_addr_o, 32'h0);
    chk("t6_wrap_addr0", w_addr, 32'hFFFF_FFFC);
    exp_q.push_back({32'h2002_0005, 32'h4});
    cyc(); cyc();
    chk("t6_valid", valid_if_o, 1);
    chk("t6_wrap_valid", w_valid, 1);
    chk("t6_wrap_instr", w_instr, 32'h1111_2222);
    chk("t6_wrap_done_pc4", w_pc4, 32'h0);
    chk("t6_wrap_state", w_state, 2);
    cyc();
    chk("t6_wrap_next_req", w_req, 1);
    chk("t6_wrap_next_addr", w_addr, 32'h0);
    chk("t6_next_addr", imem_addr_o, 32'h4);

    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Fetch stage of the 5-stage pipelined MIPS core. Sits directly upstream of the IF/ID pipeline register.
- Owns the PC and runs a single-outstanding request/response handshake with instruction memory.
- Presents the fetched instruction, its PC+4 and a valid flag to IF/ID.
- Accepts stall from the hazard unit and branch/jump redirects from decode.

Parameters:
- WIDTH, 32, data/address width.
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset
- stall_i  in  1  hazard-unit stall; holds the current fetched instruction
- redirect_i  in  1  branch taken / jump from decode
- redirect_pc_i  in  WIDTH  redirect target
- imem_req_o  out  1  request valid
- imem_addr_o  out  WIDTH  request word address
- imem_ready_i  in  1  memory accepts request this cycle
- imem_rvalid_i  in  1  read data valid
- imem_rdata_i  in  WIDTH  read data
- instr_if32  out  WIDTH  fetched instruction; 0 (NOP) when not valid
- pc_plus4_if32  out  WIDTH  PC of the fetched instruction + 4
- valid_if_o  out  1  instr_if32 is a real instruction

Behaviour:
- Reset: reset_i asynchronous, active-high; clock clk_i, rising edge. On reset:
  - pc = RESET_PC, state = REQ, discard = 0, instruction hold register = 0.
  - valid_if_o = 0, instr_if32 = 0, pc_plus4_if32 = RESET_PC + 4, imem_req_o = 1 combinationally after reset.
- Reset mid-transaction abandons any outstanding request. An imem_rvalid_i arriving after reset is ignored unless the unit is in WAIT, so the memory model must also reset.
- imem_addr_o = pc at all times. imem_req_o = (state == REQ).
- pc_plus4_if32 = pc + 4, combinational, modulo 2^WIDTH, so 0xFFFF_FFFC wraps to 0.
- instr_if32 = valid_if_o ? hold : 0. valid_if_o = (state == DONE).
- FSM states REQ, WAIT, DONE. Redirect has priority over every other event in every state.
  - REQ:
    - redirect_i -> pc <= {redirect_pc_i[WIDTH-1:2], 2'b00}; stay REQ.
    - Otherwise imem_ready_i -> WAIT.
  - WAIT:
    - redirect_i -> pc <= target and discard <= 1; stay WAIT. If imem_rvalid_i arrives in the same cycle, the data is dropped, discard <= 0 and the next state is REQ.
    - imem_rvalid_i with discard = 1 -> drop data, discard <= 0, next state REQ.
    - imem_rvalid_i with discard = 0 -> hold <= imem_rdata_i, next state DONE.
  - DONE:
    - redirect_i -> pc <= target, next state REQ; valid drops.
    - stall_i = 1 -> hold everything.
    - stall_i = 0 -> instruction is consumed by IF/ID this edge; pc <= pc + 4, next state REQ.
- imem_rvalid_i outside WAIT is ignored.
- Latency:
  - Request issued in the cycle state enters REQ.
  - Zero-wait memory (ready = 1, rvalid the cycle after acceptance): instruction valid 2 cycles after REQ entry.
  - Sustained throughput: 1 instruction per 3 cycles (REQ, WAIT, DONE).
- The hazard unit drives the IF/ID enable with !stall_i and asserts IF/ID flush on redirect. On non-valid cycles IF/ID receives instr = 0, i.e. a NOP bubble.
- stall_i in REQ or WAIT has no effect: the PC only advances from DONE.

Test Plan:
- Reset release, zero-wait memory returning 0x2002_0005 for address 0:
  - imem_req_o = 1, addr = 0 at cycle 0.
  - valid_if_o = 1, instr = 0x2002_0005, pc_plus4 = 4 at cycle 2.
  - Next request at addr 4 on cycle 3.
- DONE with stall_i = 1 for 3 cycles: instr, pc_plus4 and valid held constant, imem_req_o = 0. Release stall: pc advances by exactly 4 and no instruction is skipped or duplicated.
- redirect_i with target 0x0000_0043 while in WAIT (memory rvalid 2 cycles later):
  - Returned data discarded, valid_if_o stays 0.
  - Next request addr = 0x0000_0040.
- redirect_i and imem_rvalid_i in the same WAIT cycle: data dropped, next cycle REQ at the target address, valid_if_o = 0.
- imem_ready_i held low for 4 cycles in REQ: imem_req_o and addr stable throughout. Redirect in the 2nd cycle changes addr to the new target on the next cycle.
- Reset asserted asynchronously mid-WAIT:
  - Outputs return immediately to valid = 0, instr = 0, pc_plus4 = RESET_PC + 4.
  - RESET_PC = 0xFFFF_FFFC: pc_plus4 = 0 and the next sequential fetch address wraps to 0.
